// File: rtl/data_rx_unit.sv
// data_rx_unit: receive one framed link burst into a local buffer, then let the GPP drain it
// Ports:
//   clk, rst (async active-low)
//   data_rx_flag_out, data_rx_node_id    : arm pulse and expected sender id from the control plane
//   link_valid, link_word                : link receiver stream, header {src,len} then payload {-,data}
//   gpp_rd_en, gpp_rd_data               : GPP drain port, 1-cycle registered read
//   rx_word_count                        : words currently held in the buffer
//   data_rx_complete_flag, rx_busy, rx_error : status back to the control plane
module data_rx_unit #(
  parameter int DEPTH   = 16,
  parameter int TIMEOUT = 1024,
  parameter int CW      = $clog2(DEPTH) + 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          data_rx_flag_out,
  input  logic [15:0]   data_rx_node_id,
  input  logic          link_valid,
  input  logic [31:0]   link_word,
  input  logic          gpp_rd_en,
  output logic [15:0]   gpp_rd_data,
  output logic [CW-1:0] rx_word_count,
  output logic          data_rx_complete_flag,
  output logic          rx_busy,
  output logic          rx_error
);
  localparam int AW = $clog2(DEPTH);
  localparam int TW = $clog2(TIMEOUT) + 1;
  typedef enum logic [1:0] {IDLE, WAIT_HDR, RECV, DROP} state_t;
  state_t        state_q, state_d;
  logic [15:0]   exp_id_q, exp_id_d;
  logic [15:0]   remain_q, remain_d;
  logic [AW-1:0] wptr_q, wptr_d, rptr_q, rptr_d;
  logic [CW-1:0] count_q, count_d;
  logic [TW-1:0] tcnt_q, tcnt_d;
  logic          ret_hdr_q, ret_hdr_d;
  logic          err_q, err_d;
  logic          done_q, done_d;
  logic [15:0]   rd_data_q;
  logic          wr, rd;
  logic [15:0]   mem [DEPTH];
  logic [15:0]   hdr_src, hdr_len;
  assign hdr_src = link_word[31:16];
  assign hdr_len = link_word[15:0];
  always_comb begin
    state_d   = state_q;
    exp_id_d  = exp_id_q;
    remain_d  = remain_q;
    wptr_d    = wptr_q;
    rptr_d    = rptr_q;
    count_d   = count_q;
    tcnt_d    = tcnt_q;
    ret_hdr_d = ret_hdr_q;
    err_d     = err_q;
    done_d    = 1'b0;
    wr        = 1'b0;
    rd        = 1'b0;
    case (state_q)
      IDLE:
        if (data_rx_flag_out) begin
          exp_id_d = data_rx_node_id;
          wptr_d   = '0;
          rptr_d   = '0;
          count_d  = '0;
          tcnt_d   = '0;
          err_d    = 1'b0;
          state_d  = WAIT_HDR;
        end else if (gpp_rd_en && count_q != '0) begin
          rd      = 1'b1;
          rptr_d  = rptr_q + 1'b1;
          count_d = count_q - 1'b1;
        end
      WAIT_HDR:
        if (link_valid) begin
          if (hdr_src != exp_id_q) begin
            err_d     = 1'b1;
            remain_d  = hdr_len;
            ret_hdr_d = 1'b1;
            state_d   = DROP;
          end else if (hdr_len == '0) begin
            done_d  = 1'b1;
            state_d = IDLE;
          end else if (hdr_len <= 16'(DEPTH)) begin
            remain_d = hdr_len;
            state_d  = RECV;
          end else begin
            err_d     = 1'b1;
            remain_d  = hdr_len;
            ret_hdr_d = 1'b0;
            state_d   = DROP;
          end
        end else if (tcnt_q == TW'(TIMEOUT - 1)) begin
          err_d   = 1'b1;
          state_d = IDLE;
        end else begin
          tcnt_d = tcnt_q + 1'b1;
        end
      RECV:
        if (link_valid) begin
          wr       = 1'b1;
          wptr_d   = wptr_q + 1'b1;
          count_d  = count_q + 1'b1;
          remain_d = remain_q - 1'b1;
          if (remain_q == 16'd1) begin
            done_d  = 1'b1;
            state_d = IDLE;
          end
        end
      DROP:
        // a zero-length mismatched header leaves nothing to discard
        if (remain_q == '0 || (link_valid && remain_q == 16'd1)) begin
          remain_d = '0;
          state_d  = ret_hdr_q ? WAIT_HDR : IDLE;
          tcnt_d   = ret_hdr_q ? '0 : tcnt_q;
        end else if (link_valid) begin
          remain_d = remain_q - 1'b1;
        end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= IDLE;
      exp_id_q  <= '0;
      remain_q  <= '0;
      wptr_q    <= '0;
      rptr_q    <= '0;
      count_q   <= '0;
      tcnt_q    <= '0;
      ret_hdr_q <= 1'b0;
      err_q     <= 1'b0;
      done_q    <= 1'b0;
      rd_data_q <= '0;
    end else begin
      state_q   <= state_d;
      exp_id_q  <= exp_id_d;
      remain_q  <= remain_d;
      wptr_q    <= wptr_d;
      rptr_q    <= rptr_d;
      count_q   <= count_d;
      tcnt_q    <= tcnt_d;
      ret_hdr_q <= ret_hdr_d;
      err_q     <= err_d;
      done_q    <= done_d;
      if (rd) rd_data_q <= mem[rptr_q];
    end
  end
  always_ff @(posedge clk) begin
    if (wr) mem[wptr_q] <= link_word[15:0];
  end
  assign gpp_rd_data           = rd_data_q;
  assign rx_word_count         = count_q;
  assign data_rx_complete_flag = done_q;
  assign rx_busy               = state_q != IDLE;
  assign rx_error              = err_q;
endmodule

// File: doc/data_rx_unit.md
# data_rx_unit

Receive-side data-plane engine for a node's communications processor. It is armed by the control plane through `data_rx_flag_out` and `data_rx_node_id`, and accepts one framed burst from the photonic data-link receiver. It buffers the payload locally and signals `data_rx_complete_flag` back to the control plane. The general-purpose processor (GPP) then drains the buffer over a simple read port.

## Interface

Parameters:
- `DEPTH`, 16: payload buffer depth in 16-bit words; must be a power of 2.
- `TIMEOUT`, 1024: number of cycles allowed in WAIT_HDR before the unit aborts.
- `CW`, `$clog2(DEPTH)+1`: width of the word count; derived, not overridden.

Ports:
- `clk`, in, 1: the single clock; all logic is on the rising edge.
- `rst`, in, 1: reset, asynchronous and active-low.
- `data_rx_flag_out`, in, 1: arm request from the control plane; a single-cycle pulse.
- `data_rx_node_id`, in, 16: expected sender node, sampled when the arm is accepted.
- `link_valid`, in, 1: link receiver word strobe; there is no backpressure.
- `link_word`, in, 32: link word.
  - Header format: {src_id[15:0], length[15:0]}.
  - Payload format: {unused[15:0], data[15:0]}.
- `gpp_rd_en`, in, 1: GPP buffer read request.
- `gpp_rd_data`, out, 16: buffer read data, registered.
- `rx_word_count`, out, CW: number of words currently held in the buffer.
- `data_rx_complete_flag`, out, 1: one-cycle pulse when a valid burst has been fully received.
- `rx_busy`, out, 1: high in every state except IDLE.
- `rx_error`, out, 1: sticky error flag; cleared on the next accepted arm.

## Operation

States: IDLE, WAIT_HDR, RECV, DROP.

IDLE:
- `data_rx_flag_out`=1 arms the unit:
  - latches `exp_id` from `data_rx_node_id`;
  - clears the buffer (count=0, write pointer=0, read pointer=0);
  - clears `rx_error` and the timeout counter;
  - moves to WAIT_HDR.
- `link_valid` in IDLE is ignored.

WAIT_HDR, on `link_valid`:
- src_id≠`exp_id`: set `rx_error`, load `remain`=length, go to DROP with `ret`=WAIT_HDR.
- src_id=`exp_id` and length=0: pulse complete, go to IDLE.
- src_id=`exp_id` and 1≤length≤DEPTH: load `remain`=length, go to RECV.
- src_id=`exp_id` and length>DEPTH: set `rx_error`, go to DROP with `ret`=IDLE. No complete pulse is issued for this burst.
- Timeout: the counter increments every cycle without `link_valid`. When it reaches TIMEOUT-1 with no `link_valid`, set `rx_error` and go to IDLE without a complete pulse.

RECV, on each `link_valid`:
- write `link_word[15:0]` at the write pointer;
- increment the write pointer and count;
- decrement `remain`.
- When the word with `remain`=1 is accepted, pulse complete and go to IDLE.

DROP:
- each `link_valid` decrements `remain`; nothing is written.
- On `remain`=1 accepted, go to `ret`. If `ret` is WAIT_HDR, the timeout counter is cleared.
- length=0 in DROP goes to `ret` on the next cycle.

General rules:
- `data_rx_flag_out` outside IDLE is ignored; no re-arm, no clear.
- GPP read is honoured only in IDLE with count>0. It reads at the read pointer, then increments the read pointer and decrements count.
- `gpp_rd_en` with count=0, or outside IDLE, is ignored and `gpp_rd_data` holds its value.
- Pointers are log2(DEPTH) bits wide and wrap naturally. Count never exceeds DEPTH; this is guaranteed by the length check.
- `rst` asserted mid-burst aborts immediately; the remainder of the burst arriving after release is ignored (the unit is in IDLE).

## Timing

- Reset values: `gpp_rd_data`=0, `rx_word_count`=0, `data_rx_complete_flag`=0, `rx_busy`=0, `rx_error`=0. The state register resets to IDLE; `remain`, `exp_id` and the timeout counter reset to 0.
- Arm sampled in cycle N: `rx_busy`=1 in N+1. A header can be accepted from N+1 onward.
- Last payload word accepted in cycle M:
  - `data_rx_complete_flag`=1 in M+1 only;
  - `rx_busy`=0 in M+1;
  - `rx_word_count`=length in M+1.
- Back-to-back `link_valid` at full rate must be accepted with no bubbles.
- GPP read latency is 1 cycle: `gpp_rd_en` in cycle K gives data and count-1 in K+1. Back-to-back reads are allowed.
- Arm and `gpp_rd_en` in the same IDLE cycle: the arm wins and the read is dropped.
- Timeout in cycle T (counter=TIMEOUT-1, no `link_valid`): `rx_error`=1 and `rx_busy`=0 in T+1. `link_valid` in T itself is accepted as the header.

## Test plan

1. Normal burst:
   - Stimulus: reset low 2 cycles; arm with id 0x000A; header 0x000A0003; payloads 0xF0F0, 0x1234, 0xBEEF back-to-back.
   - Response: one complete pulse, count=3. Three reads return F0F0, 1234, BEEF, then count=0.
2. Wrong sender:
   - Stimulus: arm with id 0x0001; header 0x00020002 plus 2 words; then header 0x00010001 with word 0x00A5.
   - Response: `rx_error`=1, single complete pulse, count=1, read returns 0x00A5.
3. Oversize:
   - Stimulus: DEPTH=16, header 0x000A0011 followed by 17 words.
   - Response: `rx_error`=1, no complete pulse, unit returns to IDLE after the 17th word, count=0.
4. Timeout and zero length:
   - Stimulus: arm, no `link_valid` for TIMEOUT cycles; re-arm; header 0x000A0000.
   - Response: after the first arm, `rx_error`=1 at TIMEOUT+1 with no pulse. The re-arm clears the error; the zero-length header gives a complete pulse one cycle later with count=0.
5. Reset mid-burst and ignored arm:
   - Stimulus: arm during RECV; then assert `rst` after 2 of 4 words.
   - Response: the arm while busy has no effect. The reset sets all outputs to 0 asynchronously, and the remaining words after release are ignored.
